// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register (output reg + skid reg) with a registered in_ready.
// Optional downstream stall counter is enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_ctrl_d  = out_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            // Squash drops every held entry and any same-cycle input; data keeps its value.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_valid) begin
                        out_data_d = in_data;
                        out_ctrl_d = in_ctrl;
                        state_d    = StOne;
                    end
                end
                StOne: begin
                    if (in_valid && out_ready) begin
                        out_data_d = in_data;
                        out_ctrl_d = in_ctrl;
                    end else if (in_valid) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = StFull;
                    end else if (out_ready) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_ready) begin
                        out_data_d = skid_data_q;
                        out_ctrl_d = skid_ctrl_q;
                        state_d    = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StEmpty;
            out_data_q  <= '0;
            out_ctrl_q  <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_ctrl_q  <= out_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= (state_d != StFull);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != StEmpty);
    assign out_ctrl  = out_valid ? out_ctrl_q : '0;
    assign out_data  = out_data_q;

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg; expectations follow the
// PIPE_SKID_STALL_CNT_EN setting of the build.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_ctrl;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_ctrl;
    logic [31:0] out_data;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    pipe_skid_reg #(.DATA_W(32), .CTRL_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = 8'h00;
        in_data   = 32'h0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
        total++; if (out_ctrl !== 8'h00) begin bad++; $display("FAIL rst_out_ctrl got=%h exp=00", out_ctrl); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL rst_stall got=%h exp=0", stall_cnt); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 8'h01;
        for (int n = 1; n <= 8; n++) begin
            in_data = 32'(n);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready n=%0d got=%0b exp=1", n, in_ready); end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'(n) || out_ctrl !== 8'h01) begin
                bad++;
                $display("FAIL stream_out n=%0d got v=%0b d=%h c=%h exp v=1 d=%h c=01",
                         n, out_valid, out_data, out_ctrl, n);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 32'd8) begin
            bad++;
            $display("FAIL stream_drain got v=%0b c=%h d=%h exp v=0 c=00 d=8", out_valid, out_ctrl, out_data);
        end
        total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL stream_stall got=%h exp=0", stall_cnt); end
    endtask

    task automatic test_skid();
        logic [15:0] exp_stall;
`ifdef PIPE_SKID_STALL_CNT_EN
        exp_stall = 16'd4;
`else
        exp_stall = 16'd0;
`endif
        do_reset();
        in_valid = 1'b1; in_data = 32'h11; in_ctrl = 8'h05;
        tick();
        in_data = 32'h22; in_ctrl = 8'h06;
        tick();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h11 || out_ctrl !== 8'h05) begin
            bad++;
            $display("FAIL skid_full got rdy=%0b v=%0b d=%h c=%h exp rdy=0 v=1 d=11 c=05",
                     in_ready, out_valid, out_data, out_ctrl);
        end
        // Offered while FULL; must be ignored.
        in_data = 32'h99; in_ctrl = 8'h07;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (in_ready !== 1'b0 || out_data !== 32'h11 || out_ctrl !== 8'h05) begin
                bad++;
                $display("FAIL skid_hold i=%0d got rdy=%0b d=%h c=%h exp rdy=0 d=11 c=05",
                         i, in_ready, out_data, out_ctrl);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h22 || out_ctrl !== 8'h06 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL skid_pop_b got v=%0b d=%h c=%h rdy=%0b exp v=1 d=22 c=06 rdy=1",
                     out_valid, out_data, out_ctrl, in_ready);
        end
        total++; if (stall_cnt !== exp_stall) begin bad++; $display("FAIL skid_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
        tick();
        total++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin bad++; $display("FAIL skid_empty got v=%0b c=%h exp v=0 c=00", out_valid, out_ctrl); end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_data = 32'h11; in_ctrl = 8'h05;
        tick();
        in_data = 32'h22; in_ctrl = 8'h06;
        tick();
        flush = 1'b1; in_data = 32'h33; in_ctrl = 8'h08;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1 || out_data !== 32'h11) begin
            bad++;
            $display("FAIL flush_state got v=%0b c=%h rdy=%0b d=%h exp v=0 c=00 rdy=1 d=11",
                     out_valid, out_ctrl, in_ready, out_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0 || out_data === 32'h33) begin
                bad++;
                $display("FAIL flush_leak i=%0d got v=%0b d=%h exp v=0 d!=33", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_reset_flush();
        do_reset();
        in_valid = 1'b1; in_data = 32'h44; in_ctrl = 8'h09;
        tick();
        in_data = 32'h55; in_ctrl = 8'h0a;
        tick();
        tick();
        reset = 1'b1; flush = 1'b1; out_ready = 1'b1; in_data = 32'h66;
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== 8'h00 ||
            out_data !== 32'h0 || stall_cnt !== 16'h0) begin
            bad++;
            $display("FAIL rstflush got v=%0b rdy=%0b c=%h d=%h s=%h exp v=0 rdy=1 c=00 d=0 s=0",
                     out_valid, in_ready, out_ctrl, out_data, stall_cnt);
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin bad++; $display("FAIL rstflush_after got v=%0b d=%h exp v=0 d=0", out_valid, out_data); end
    endtask

    task automatic test_saturate();
        do_reset();
        in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h03;
        tick();
        in_valid = 1'b0;
`ifdef PIPE_SKID_STALL_CNT_EN
        repeat (70000) tick();
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_cnt got=%h exp=ffff", stall_cnt); end
        total++; if (out_valid !== 1'b1 || out_data !== 32'h77) begin bad++; $display("FAIL sat_hold got v=%0b d=%h exp v=1 d=77", out_valid, out_data); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (stall_cnt !== 16'hFFFF || out_valid !== 1'b0) begin bad++; $display("FAIL sat_flush got s=%h v=%0b exp s=ffff v=0", stall_cnt, out_valid); end
`else
        repeat (20) tick();
        total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL nocnt got=%h exp=0", stall_cnt); end
        total++; if (out_valid !== 1'b1 || out_data !== 32'h77) begin bad++; $display("FAIL nocnt_hold got v=%0b d=%h exp v=1 d=77", out_valid, out_data); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_reset_flush();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of the datapath payload (ALU result, store data, PC and similar).
REQ-002 Parameter CTRL_W, default 8, SHALL set the width of the control payload (MemRead, MemWrite, RegWrite, MemtoReg and similar).
REQ-003 The module SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 flush  input  1  SHALL be a synchronous kill of all held entries (branch/exception squash).
REQ-007 in_valid  input  1  SHALL mark upstream payload present.
REQ-008 in_ready  output  1  SHALL signal that this stage accepts the upstream payload this cycle.
REQ-009 in_ctrl  input  CTRL_W  SHALL be the upstream control payload.
REQ-010 in_data  input  DATA_W  SHALL be the upstream data payload.
REQ-011 out_valid  output  1  SHALL mark downstream payload present.
REQ-012 out_ready  input  1  SHALL signal that downstream accepts the payload this cycle.
REQ-013 out_ctrl  output  CTRL_W  SHALL be the downstream control payload.
REQ-014 out_data  output  DATA_W  SHALL be the downstream data payload.
REQ-015 stall_cnt  output  16  SHALL report the downstream back-pressure cycle count.

Function
REQ-016 A transfer SHALL occur on an input when in_valid&in_ready, and on an output when out_valid&out_ready.
REQ-017 Storage SHALL be one output register plus one skid register; states: EMPTY (none held), ONE (output register held), FULL (both held).
REQ-018 in_ready SHALL be a registered signal equal to 1 in EMPTY and ONE and 0 in FULL; it SHALL NOT depend combinationally on out_ready.
REQ-019 EMPTY: in_valid -> load output register, go to ONE; otherwise stay.
REQ-020 ONE: in_valid&out_ready -> replace output register, stay; in_valid&!out_ready -> load skid, go to FULL; !in_valid&out_ready -> EMPTY; otherwise hold.
REQ-021 FULL: out_ready -> skid moves to output register, go to ONE; otherwise hold both entries unchanged.
REQ-022 Latency SHALL be 1 cycle from input transfer to out_valid; sustained throughput SHALL be 1 transfer per cycle when out_ready=1.
REQ-023 Order SHALL be preserved; no payload SHALL be dropped or duplicated except by flush or reset.
REQ-024 When out_valid=0, out_ctrl SHALL be all zeros (bubble); out_data SHALL hold its last value.
REQ-025 flush SHALL take priority over every other event: next state EMPTY, in_ready=1, out_ctrl=0, and any same-cycle input is discarded.
REQ-026 Held payloads SHALL be stable while out_valid&!out_ready.

Reset
REQ-027 On reset: state EMPTY, out_valid=0, in_ready=1, out_ctrl=0, out_data=0, skid contents=0, stall_cnt=0.
REQ-028 Reset SHALL take priority over flush and over all handshakes, including mid-transfer in FULL.
REQ-029 Initial values at time zero SHALL equal the reset values.

Configuration
REQ-030 Macro PIPE_SKID_STALL_CNT_EN defined: stall_cnt SHALL increment by 1 each cycle with out_valid&!out_ready, SHALL saturate at 16'hFFFF, SHALL be cleared only by reset (not by flush).
REQ-031 Macro PIPE_SKID_STALL_CNT_EN undefined: stall_cnt SHALL be constant 0, no counter logic; the port SHALL remain present.

Verification
REQ-032 Stream of 1..8 (in_data=n, in_ctrl=8'h01) with out_ready=1 every cycle -> out_data 1..8 on consecutive cycles, each 1 cycle after acceptance, in_ready always 1.
REQ-033 Accept A=0x11, then B=0x22 with out_ready=0 -> FULL, in_ready=0 next cycle; raise out_ready 3 cycles later -> out A then B, stall_cnt=4 with macro, 0 without.
REQ-034 In FULL assert flush with in_valid=1, in_data=0x33 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, 0x33 never appears at output.
REQ-035 In FULL assert reset and flush together -> all outputs at reset values next cycle, stall_cnt=0.
REQ-036 Macro defined: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt stops at 16'hFFFF; then flush -> stall_cnt stays 16'hFFFF.
